// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the receiver has no ready input and never stalls.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PRESC_8        = 8;
    localparam int PRESC_16       = 16;
    localparam int PRESC_32       = 32;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // 2-of-3 majority used for the mid-bit vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timer and mid-bit 3-sample majority voter.
// Latency: sampled bit valid on the bit_tick cycle (edge_cnt = PRESCALE-1).
// Backpressure: none; free-running while enabled.
//
// Ports:
//   CLK, RST          clock, async active-low reset
//   i_rx              serial line (already synchronous to CLK)
//   i_clr             start-bit detected: restart the bit timer at 0
//   i_en              receiver busy (not IDLE): let the timer run
//   i_prescale        CLK cycles per bit (8, 16 or 32)
//   o_sampled_bit     majority of the three mid-bit samples
//   o_bit_tick        last cycle of the current bit period
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_rx,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [PRESC_W-1:0] i_prescale,
    output logic               o_sampled_bit,
    output logic               o_bit_tick
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] r_edge_cnt;
    logic               r_s0, r_s1, r_s2;

    logic [PRESC_W-1:0] w_half;
    logic [PRESC_W-1:0] w_last;
    logic               w_wrap;

    assign w_half = i_prescale >> 1;
    assign w_last = i_prescale - ONE;
    assign w_wrap = (r_edge_cnt == w_last);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
        end else begin
            if (i_clr || !i_en) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + ONE;
                // Three consecutive samples centred on the middle of the bit.
                if (r_edge_cnt == w_half - ONE) r_s0 <= i_rx;
                if (r_edge_cnt == w_half)       r_s1 <= i_rx;
                if (r_edge_cnt == w_half + ONE) r_s2 <= i_rx;
            end
        end
    end

    assign o_bit_tick    = i_en && !i_clr && w_wrap;
    assign o_sampled_bit = maj3(r_s0, r_s1, r_s2);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first deserialise, optional parity, stop check.
// Latency: outputs pulse at t0 + N*PRESCALE + 1 (+2 with UART_RX_SYNC_EN), N = frame bits.
// Backpressure: none; DATA_VALID is a one-cycle pulse the consumer must take.
//
// Ports:
//   CLK, RST      clock, async active-low reset
//   RX_IN         serial line, idle high
//   PAR_EN        frame carries a parity bit
//   PAR_TYP       0 = even, 1 = odd parity
//   PRESCALE      CLK cycles per bit (8, 16, 32), static outside IDLE
//   P_DATA        last error-free byte
//   DATA_VALID    one-cycle pulse when P_DATA updates
//   PAR_ERR       one-cycle pulse on parity mismatch
//   STP_ERR       one-cycle pulse when the stop bit samples 0
// Build option: UART_RX_SYNC_EN adds a 2-flop input synchronizer on RX_IN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    // bit_cnt counts every bit of the frame (start = 0), so it must reach DATA_WIDTH+2.
    localparam int BC_W = $clog2(DATA_WIDTH + 3);

    rx_state_t             r_state;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_err;

    logic w_rx;
    logic w_start_det;
    logic w_busy;
    logic w_bit;
    logic w_tick;
    logic w_par_exp;

`ifdef UART_RX_SYNC_EN
    // Flops reset to the idle-line level so reset release never looks like a start bit.
    logic [1:0] r_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    assign w_start_det = (r_state == IDLE) && !w_rx;
    assign w_busy      = (r_state != IDLE);
    assign w_par_exp   = (^r_shift) ^ (r_par_typ == PAR_ODD);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .i_rx          (w_rx),
        .i_clr         (w_start_det),
        .i_en          (w_busy),
        .i_prescale    (PRESCALE),
        .o_sampled_bit (w_bit),
        .o_bit_tick    (w_tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_err  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (w_tick) r_bit_cnt <= r_bit_cnt + BC_W'(1);

            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_state   <= START;
                        r_bit_cnt <= '0;
                        r_par_err <= 1'b0;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                    end
                end
                START: begin
                    // A high majority means the falling edge was a glitch.
                    if (w_tick) r_state <= w_bit ? IDLE : DATA;
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == BC_W'(DATA_WIDTH)) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        if (w_bit != w_par_exp) r_par_err <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        PAR_ERR <= r_par_err;
                        STP_ERR <= !w_bit;
                        if (!r_par_err && w_bit) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= r_shift;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] d;
        logic       v;
        logic       pe;
        logic       se;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Any pulse must match the head of the scoreboard, including its exact cycle.
    always @(negedge CLK) begin
        if (RST === 1'b1 && (DATA_VALID || PAR_ERR || STP_ERR)) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("data_valid", DATA_VALID, e.v);
                chk("par_err", PAR_ERR, e.pe);
                chk("stp_err", STP_ERR, e.se);
                chk("p_data", P_DATA, e.d);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) step();
    endtask

    // Drives one frame starting in the current cycle. slip = extra cycles before
    // the DUT can see the start bit; abort_c >= 0 pulls reset at that frame cycle.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic pbit, input logic sbit,
                              input int glitch_c, input int slip, input int abort_c);
        int   n;
        logic bv;
        logic pexp, perr, serr, v;
        exp_t e;
        n = 10 + (pen ? 1 : 0);
        PRESCALE = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (abort_c < 0) begin
            pexp = (^d) ^ ptyp;
            perr = pen && (pbit != pexp);
            serr = !sbit;
            v    = !perr && !serr;
            e.at = cyc + slip + n * p + 1 + SYNC_LAT;
            e.v  = v;
            e.pe = perr;
            e.se = serr;
            e.d  = v ? d : last_good;
            if (v) last_good = d;
            sb.push_back(e);
        end
        for (int c = 0; c < n * p; c++) begin
            int b;
            b = c / p;
            if (b == 0)            bv = 1'b0;
            else if (b <= 8)       bv = d[b-1];
            else if (pen && b == 9) bv = pbit;
            else                   bv = sbit;
            if (c == glitch_c) bv = ~bv;
            RX_IN = bv;
            if (c == abort_c) begin
                RST = 1'b0;
                #1;
                chk("rst_p_data", P_DATA, 8'h00);
                chk("rst_data_valid", DATA_VALID, 1'b0);
                chk("rst_par_err", PAR_ERR, 1'b0);
                chk("rst_stp_err", STP_ERR, 1'b0);
                RX_IN = 1'b1;
                last_good = 8'h00;
                step();
                step();
                RST = 1'b1;
                return;
            end
            step();
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        int wait_cnt;
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        PRESCALE = 6'(PRESC_8);
        #3;
        chk("reset_p_data", P_DATA, 8'h00);
        chk("reset_data_valid", DATA_VALID, 1'b0);
        chk("reset_par_err", PAR_ERR, 1'b0);
        chk("reset_stp_err", STP_ERR, 1'b0);
        repeat (3) step();
        RST = 1'b1;
        idle(4);

        // 0xA5, even parity (bit 0), PRESCALE 8: pulse at t0+89.
        send_frame(8'hA5, PRESC_8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 0, -1);
        idle(8);

        // 0x3C then 0xC3 driven right after the stop bit; the DUT is still in STOP
        // during that first low cycle, so detection of the second start slips by one.
        send_frame(8'h3C, PRESC_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, -1);
        send_frame(8'hC3, PRESC_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1, -1);
        idle(8);

        // Start glitch: 3 low cycles is shorter than the mid-bit sample window.
        PRESCALE = 6'(PRESC_8);
        RX_IN = 1'b0;
        repeat (3) step();
        idle(24);
        chk("glitch_p_data", P_DATA, last_good);

        // 0x0F with odd parity needs parity bit 1; sending 0 must flag PAR_ERR.
        send_frame(8'h0F, PRESC_8, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, 0, -1);
        idle(8);

        // 0x55 with stop bit 0 at PRESCALE 32: STP_ERR at t0+321.
        send_frame(8'h55, PRESC_32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 0, -1);
        idle(8);

        // 0x55 with a one-cycle high on the mid-bit sample (edge_cnt 16) of data bit 1.
        send_frame(8'h55, PRESC_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 2 * 32 + 1 + 16, 0, -1);
        idle(8);

        // Reset in the middle of 0xFF's data bits, then a clean 0x81.
        send_frame(8'hFF, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, 40);
        idle(30);
        chk("post_reset_no_pending", sb.size(), 0);
        send_frame(8'h81, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, -1);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 500) begin
            step();
            wait_cnt++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        idle(10);
        chk("final_p_data", P_DATA, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
